// File: rtl/oc_ctrl_pkg.sv
// Shared types and helpers for the serial ones-count controller.
package oc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } oc_state_t;

  function automatic int ceil_div3(input int w);
    return (w + 2) / 3;
  endfunction

endpackage

// File: rtl/ones3_cell.sv
// Combinational 3-input ones counter: {y1,y0} = number of ones in a,b,c.
module ones3_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y1,
  output logic y0
);

  assign y1 = (a & b) | (a & c) | (b & c);
  assign y0 = a ^ b ^ c;

endmodule

// File: rtl/serial_ones_counter.sv
// Population count of a WIDTH-bit word using one shared ones3_cell,
// fed three bits at a time with SETTLE hold cycles per group.
module serial_ones_counter
  import oc_ctrl_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int NG  = ceil_div3(WIDTH);
  localparam int SW  = NG * 3;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int STW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  oc_state_t        r_state;
  oc_state_t        w_state_next;
  logic [SW-1:0]    r_shift;
  logic [GW-1:0]    r_grp;
  logic [STW-1:0]   r_settle;
  logic [CW-1:0]    r_count;
  logic             w_y1;
  logic             w_y0;
  logic             w_step;
  logic             w_last;

  ones3_cell u_cell (
    .a  (r_shift[2]),
    .b  (r_shift[1]),
    .c  (r_shift[0]),
    .y1 (w_y1),
    .y0 (w_y0)
  );

  // A group is consumed only once its hold window has expired.
  assign w_step = (r_state == FEED) && (r_settle == '0);
  assign w_last = (r_grp == GW'(NG - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = FEED;
      FEED:    if (w_step && w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == IDLE);
    busy  = (r_state == FEED);
    done  = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_grp    <= '0;
      r_settle <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift  <= SW'(data_in);
            r_grp    <= '0;
            r_settle <= STW'(SETTLE);
            r_count  <= '0;
          end
        end
        FEED: begin
          if (r_settle != '0) begin
            r_settle <= r_settle - STW'(1);
          end else begin
            r_count  <= r_count + CW'({w_y1, w_y0});
            r_shift  <= r_shift >> 3;
            r_settle <= STW'(SETTLE);
            if (!w_last) r_grp <= r_grp + GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign count = r_count;

endmodule
